// File: rtl/alu_seq_ctrl.sv
// Sequencing controller for the shared slice-built ALU: issues single-pass ops
// directly and runs MULTU as a 32-step shift-add loop on the ALU's ADD path.
module alu_seq_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [5:0]       alu_signal,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_cout
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  localparam logic [5:0] F_ADD   = 6'd32;
  localparam logic [5:0] F_SUB   = 6'd34;
  localparam logic [5:0] F_AND   = 6'd36;
  localparam logic [5:0] F_OR    = 6'd37;
  localparam logic [5:0] F_SLT   = 6'd42;
  localparam logic [5:0] F_MULTU = 6'd25;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_MUL,
    S_DONE
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [5:0]         r_funct;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_hi_acc;
  logic [WIDTH-1:0]   r_lo_acc;
  logic [WIDTH-1:0]   r_mcand;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_err;
  logic [WIDTH-1:0]   r_result;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               w_single;
  logic [2*WIDTH-1:0] w_acc_next;

  assign w_single = (funct == F_ADD) || (funct == F_SUB) || (funct == F_AND) ||
                    (funct == F_OR)  || (funct == F_SLT);

  // The carry becomes the new MSB and the whole product pair shifts right one bit.
  assign w_acc_next = {alu_cout, alu_result, r_lo_acc[WIDTH-1:1]};

  assign result = r_result;
  assign hi     = r_hi;
  assign lo     = r_lo;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    w_next     = r_state;
    busy       = 1'b0;
    done       = 1'b0;
    err        = 1'b0;
    alu_signal = '0;
    alu_a      = '0;
    alu_b      = '0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (w_single)                w_next = S_EXEC;
          else if (funct == F_MULTU)   w_next = S_MUL;
          else                         w_next = S_DONE;
        end
      end
      S_EXEC: begin
        busy       = 1'b1;
        alu_signal = r_funct;
        alu_a      = r_a;
        alu_b      = r_b;
        w_next     = S_DONE;
      end
      S_MUL: begin
        busy       = 1'b1;
        alu_signal = F_ADD;
        alu_a      = r_hi_acc;
        alu_b      = r_lo_acc[0] ? r_mcand : '0;
        if (r_cnt == CNT_LAST) w_next = S_DONE;
      end
      S_DONE: begin
        done   = 1'b1;
        err    = r_err;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      r_funct  <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_hi_acc <= '0;
      r_lo_acc <= '0;
      r_mcand  <= '0;
      r_cnt    <= '0;
      r_err    <= 1'b0;
      r_result <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (w_single) begin
              r_funct <= funct;
              r_a     <= src_a;
              r_b     <= src_b;
            end else if (funct == F_MULTU) begin
              r_hi_acc <= '0;
              r_lo_acc <= src_b;
              r_mcand  <= src_a;
              r_cnt    <= '0;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        S_EXEC: r_result <= alu_result;
        S_MUL: begin
          {r_hi_acc, r_lo_acc} <= w_acc_next;
          r_cnt                <= r_cnt + CNT_W'(1);
          if (r_cnt == CNT_LAST) {r_hi, r_lo} <= w_acc_next;
        end
        S_DONE: r_err <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Self-checking bench for alu_seq_ctrl: behavioural ALU plus a reference model of
// op results, latency, busy/done/err sequencing, start-while-busy and mid-op reset.
module tb_alu_seq_ctrl;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [5:0]   funct;
  logic [W-1:0] src_a, src_b;
  logic         busy, done, err;
  logic [W-1:0] result, hi, lo;
  logic [5:0]   alu_signal;
  logic [W-1:0] alu_a, alu_b, alu_result;
  logic         alu_cout;

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] m_result, m_hi, m_lo;

  alu_seq_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .funct(funct),
    .src_a(src_a), .src_b(src_b),
    .busy(busy), .done(done), .err(err),
    .result(result), .hi(hi), .lo(lo),
    .alu_signal(alu_signal), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result), .alu_cout(alu_cout)
  );

  always #5 clk = ~clk;

  // Behavioural stand-in for the slice-built ALU.
  always_comb begin
    logic [W:0] t;
    t          = '0;
    alu_result = '0;
    alu_cout   = 1'b0;
    case (alu_signal)
      6'd36: alu_result = alu_a & alu_b;
      6'd37: alu_result = alu_a | alu_b;
      6'd32: begin t = {1'b0, alu_a} + {1'b0, alu_b}; {alu_cout, alu_result} = t; end
      6'd34: begin t = {1'b0, alu_a} + {1'b0, ~alu_b} + 33'd1; {alu_cout, alu_result} = t; end
      6'd42: alu_result = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
      default: ;
    endcase
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic bit is_single(input logic [5:0] f);
    return f == 6'd32 || f == 6'd34 || f == 6'd36 || f == 6'd37 || f == 6'd42;
  endfunction

  // Update the reference result registers from the spec's arithmetic rules.
  task automatic model_op(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [63:0] p;
    case (f)
      6'd36: m_result = a & b;
      6'd37: m_result = a | b;
      6'd32: m_result = a + b;
      6'd34: m_result = a - b;
      6'd42: m_result = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      6'd25: begin p = 64'(a) * 64'(b); m_hi = p[63:32]; m_lo = p[31:0]; end
      default: ;
    endcase
  endtask

  // Called just after a falling edge; returns just after a falling edge.
  task automatic run_op(input string tag, input logic [5:0] f, input logic [W-1:0] a,
                        input logic [W-1:0] b, input int inject_at);
    int lat;
    logic [39:0] busy_obs, busy_exp, done_obs, done_exp;
    logic err_obs, both_hi;
    logic [5:0] sig1;
    logic [W-1:0] a1, b1;
    lat = is_single(f) ? 2 : (f == 6'd25) ? 33 : 1;
    busy_obs = '0; busy_exp = '0; done_obs = '0; done_exp = '0;
    err_obs = 1'b0; both_hi = 1'b0; sig1 = '0; a1 = '0; b1 = '0;
    for (int c = 1; c < lat; c++) busy_exp[c] = 1'b1;
    done_exp[lat] = 1'b1;
    start = 1'b1; funct = f; src_a = a; src_b = b;
    @(posedge clk); #1;
    start = 1'b0; funct = 6'($urandom); src_a = $urandom; src_b = $urandom;
    for (int c = 1; c <= lat + 2; c++) begin
      @(negedge clk);
      start = (c == inject_at);
      if (c == inject_at) begin funct = 6'd32; src_a = 32'd7; src_b = 32'd5; end
      busy_obs[c] = busy;
      done_obs[c] = done;
      if (done) err_obs = err;
      if (busy && done) both_hi = 1'b1;
      if (c == 1) begin sig1 = alu_signal; a1 = alu_a; b1 = alu_b; end
    end
    start = 1'b0;
    model_op(f, a, b);
    check({tag, "_busy_seq"}, 64'(busy_obs), 64'(busy_exp));
    check({tag, "_done_seq"}, 64'(done_obs), 64'(done_exp));
    check({tag, "_busy_done_overlap"}, 64'(both_hi), 64'(0));
    check({tag, "_err"}, 64'(err_obs), 64'(lat == 1));
    if (is_single(f))
      check({tag, "_alu_drive"}, {sig1, a1, b1[25:0]}, {f, a, b[25:0]});
    else if (f == 6'd25)
      check({tag, "_alu_drive"}, {sig1, a1, b1[25:0]},
            {6'd32, 32'd0, (b[0] ? a[25:0] : 26'd0)});
    else
      check({tag, "_alu_idle"}, {sig1, a1, b1[25:0]}, 64'd0);
    check({tag, "_result"}, 64'(result), 64'(m_result));
    check({tag, "_hilo"}, {hi, lo}, {m_hi, m_lo});
  endtask

  localparam logic [5:0] FTAB [8] = '{6'd36, 6'd37, 6'd32, 6'd34, 6'd42, 6'd25, 6'h3F, 6'd0};

  initial begin
    logic [5:0] f;
    logic [W-1:0] a, b;
    rst = 1'b1; start = 1'b0; funct = '0; src_a = '0; src_b = '0;
    m_result = '0; m_hi = '0; m_lo = '0;
    #1;
    check("reset_ctrl", {busy, done, err}, 64'd0);
    check("reset_regs", {result, hi}, 64'd0);
    check("reset_alu", {alu_signal, alu_a, lo[25:0]}, 64'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    run_op("add_7_5", 6'd32, 32'd7, 32'd5, 0);
    check("add_7_5_value", 64'(result), 64'h0000_000C);
    run_op("sub_5_7", 6'd34, 32'd5, 32'd7, 0);
    check("sub_value", 64'(result), 64'hFFFF_FFFE);
    run_op("slt_3_9", 6'd42, 32'd3, 32'd9, 0);
    check("slt_value", 64'(result), 64'd1);
    run_op("mul_max", 6'd25, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    check("mul_max_value", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
    run_op("mul_2p16", 6'd25, 32'h0001_0000, 32'h0001_0000, 0);
    check("mul_2p16_value", {hi, lo}, 64'h0000_0001_0000_0000);
    run_op("mul_inject", 6'd25, 32'h1234_5678, 32'h9ABC_DEF1, 10);
    run_op("illegal_3f", 6'h3F, 32'd1, 32'd2, 0);

    // Reset mid-MULTU: abort, outputs return to reset values at once.
    start = 1'b1; funct = 6'd25; src_a = 32'hDEAD_BEEF; src_b = 32'h0BAD_F00D;
    @(posedge clk); #1; start = 1'b0;
    repeat (15) @(negedge clk);
    rst = 1'b1; #1;
    check("midrst_ctrl", {busy, done, err}, 64'd0);
    check("midrst_regs", {result, hi}, 64'd0);
    check("midrst_lo_alu", {lo, alu_signal, alu_a[25:0]}, 64'd0);
    m_result = '0; m_hi = '0; m_lo = '0;
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    check("midrst_no_done", 64'(done), 64'd0);
    run_op("add_after_rst", 6'd32, 32'd100, 32'd23, 0);

    for (int i = 0; i < 30; i++) begin
      f = FTAB[$urandom_range(0, 7)];
      a = $urandom; b = $urandom;
      if ($urandom_range(0, 3) == 0) b = a;
      run_op($sformatf("rnd%0d", i), f, a, b, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
